// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car controller and its display consumer.
package elevator_pkg;

    // sim_state encodings consumed by vgaController.
    localparam logic [1:0] SIM_IDLE      = 2'b00;
    localparam logic [1:0] SIM_MOVE_UP   = 2'b01;
    localparam logic [1:0] SIM_MOVE_DOWN = 2'b10;
    localparam logic [1:0] SIM_DOOR      = 2'b11;

    typedef enum logic [1:0] {
        StIdle     = SIM_IDLE,
        StMoveUp   = SIM_MOVE_UP,
        StMoveDown = SIM_MOVE_DOWN,
        StDoor     = SIM_DOOR
    } car_state_t;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_t;

    typedef struct packed {
        car_state_t state;
        dir_t       dir;
    } decision_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..cycles-1, never less than one.
    function automatic int unsigned timer_width(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable, enable-gated down-counter with a zero flag; shared by travel and door timing.
module dwell_timer
    import elevator_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN elevator car controller: latches calls, times travel and door dwell, drives sim_state.
// Optional emergency-stop input is enabled by defining ELEVATOR_ESTOP_EN.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS    = 8,
    parameter int unsigned TRAVEL_CYCLES = 16,
    parameter int unsigned DOOR_CYCLES   = 32,
    parameter int unsigned FLOOR_W       = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
`ifdef ELEVATOR_ESTOP_EN
    input  logic                  estop,
`endif
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [NUM_FLOORS-1:0] destination,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [1:0]            sim_state,
    output logic                  door_open,
    output logic                  arrive
);

    localparam int unsigned TIMER_W = timer_width(max_u(TRAVEL_CYCLES, DOOR_CYCLES));
    localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

    car_state_t            state_q, state_d;
    dir_t                  dir_q, dir_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic                  arrive_q, arrive_d;

    logic                  stop;
    logic                  step_en;
    logic                  timer_zero;
    logic                  timer_load;
    logic [TIMER_W-1:0]    timer_load_val;
    logic [NUM_FLOORS-1:0] cur_oh;
    logic [NUM_FLOORS-1:0] call_eff;
    logic [NUM_FLOORS-1:0] clear;
    logic [NUM_FLOORS-1:0] eval_req;
    logic [FLOOR_W-1:0]    eval_floor;
    logic                  take;
    decision_t             dec;

`ifdef ELEVATOR_ESTOP_EN
    assign stop = estop;
`else
    assign stop = 1'b0;
`endif

    assign step_en = en & ~stop;

    // Serve the current floor first, then keep direction, then reverse, else rest.
    function automatic decision_t decide(input logic [NUM_FLOORS-1:0] req,
                                         input logic [FLOOR_W-1:0]    floor,
                                         input dir_t                  dir);
        logic      above;
        logic      below;
        decision_t res;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (req[i] && (i > int'(floor))) above = 1'b1;
            if (req[i] && (i < int'(floor))) below = 1'b1;
        end
        res.dir = dir;
        if (req[floor]) begin
            res.state = StDoor;
        end else if ((dir == DirUp) && above) begin
            res.state = StMoveUp;
        end else if ((dir == DirDown) && below) begin
            res.state = StMoveDown;
        end else if (above) begin
            res.state = StMoveUp;
            res.dir   = DirUp;
        end else if (below) begin
            res.state = StMoveDown;
            res.dir   = DirDown;
        end else begin
            res.state = StIdle;
        end
        return res;
    endfunction

    always_comb begin
        cur_oh         = NUM_FLOORS'(1) << floor_q;
        // A call to the floor whose door is open is served by that open door, not latched.
        call_eff       = (state_q == StDoor) ? (call_req & ~cur_oh) : call_req;
        state_d        = state_q;
        dir_d          = dir_q;
        floor_d        = floor_q;
        arrive_d       = 1'b0;
        clear          = '0;
        take           = 1'b0;
        eval_floor     = floor_q;
        eval_req       = pending_q | call_eff;
        timer_load     = 1'b0;
        timer_load_val = TRAVEL_LOAD;

        if (step_en) begin
            case (state_q)
                StIdle: begin
                    // Idle acts on latched requests only, so a fresh call costs one latch edge.
                    take     = 1'b1;
                    eval_req = pending_q;
                end
                StMoveUp, StMoveDown: begin
                    if (timer_zero) begin
                        take       = 1'b1;
                        eval_floor = (state_q == StMoveUp) ? floor_q + FLOOR_W'(1)
                                                           : floor_q - FLOOR_W'(1);
                        floor_d    = eval_floor;
                    end
                end
                StDoor: begin
                    if (call_req[floor_q]) begin
                        timer_load     = 1'b1;
                        timer_load_val = DOOR_LOAD;
                    end else if (timer_zero) begin
                        take = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        dec = decide(eval_req, eval_floor, dir_q);

        if (take) begin
            state_d = dec.state;
            dir_d   = dec.dir;
            case (dec.state)
                StMoveUp, StMoveDown: begin
                    timer_load     = 1'b1;
                    timer_load_val = TRAVEL_LOAD;
                end
                StDoor: begin
                    timer_load     = 1'b1;
                    timer_load_val = DOOR_LOAD;
                    clear          = NUM_FLOORS'(1) << eval_floor;
                    arrive_d       = 1'b1;
                end
                default: ;
            endcase
        end

        pending_d = (pending_q | call_eff) & ~clear;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            dir_q     <= DirUp;
            floor_q   <= '0;
            pending_q <= '0;
            arrive_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            arrive_q  <= arrive_d;
        end
    end

    dwell_timer #(
        .WIDTH(TIMER_W)
    ) u_dwell_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (step_en),
        .load    (timer_load),
        .load_val(timer_load_val),
        .zero    (timer_zero)
    );

    assign destination = pending_q;
    assign cur_floor   = floor_q;
    assign sim_state   = state_q;
    assign door_open   = (state_q == StDoor);
    assign arrive      = arrive_q;

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Parametrised car controller for the elevator ASIC. It latches floor-call buttons into a pending-request mask and runs a SCAN (keep-direction) policy with per-floor travel and door-dwell timers. It drives the `destination` mask and the 2-bit `sim_state` consumed by `vgaController`, replacing the free-running test counter that fed the display.

## Interface
- `NUM_FLOORS`, 8: number of floors, ≥2. Sets the width of `call_req` and `destination`.
- `TRAVEL_CYCLES`, 16: enabled cycles needed to move one floor, ≥1.
- `DOOR_CYCLES`, 32: enabled cycles the door stays open, ≥1.
- `FLOOR_W`, `$clog2(NUM_FLOORS)`: derived width of `cur_floor`.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: tick enable; gates timers and state transitions.
- `call_req`, in, `NUM_FLOORS`: call-button vector; bit i = call to floor i. Sampled every cycle.
- `destination`, out, `NUM_FLOORS`: registered pending-request mask.
- `cur_floor`, out, `FLOOR_W`: current car floor.
- `sim_state`, out, 2: 00 IDLE, 01 MOVE_UP, 10 MOVE_DOWN, 11 DOOR.
- `door_open`, out, 1: high exactly when the state is DOOR.
- `arrive`, out, 1: one-cycle pulse on the edge that enters DOOR.
- `estop`, in, 1: present only with `ELEVATOR_ESTOP_EN`.

## Operation
- Reset values: `destination`=0, `cur_floor`=0, `sim_state`=IDLE, `door_open`=0, `arrive`=0, timer=0, direction register `dir`=UP.
- Request latching:
  - `pending <= (pending | call_req) & ~clear`, every cycle, regardless of `en`.
  - `clear` is the one-hot arrival floor on a DOOR-entry edge; otherwise 0.
  - A call to the current floor while in DOOR is not latched. If `en`=1 on that cycle, the door timer reloads (door reopens).
- Decision function, evaluated against `pending|call_req` with the car at floor f:
  - If a request is at f → DOOR.
  - Else if any request lies ahead in `dir` → move in `dir`.
  - Else if any request lies behind → reverse `dir` and move.
  - Else → IDLE.
- IDLE: applies the decision function on each `en` cycle.
- MOVE_UP / MOVE_DOWN:
  - On entry the timer loads `TRAVEL_CYCLES-1`; it decrements on each `en` cycle.
  - On the `en` cycle with timer==0, `cur_floor` steps ±1 and the decision function is applied at the new floor.
  - Continuing in the same direction reloads the timer.
- DOOR:
  - On entry the timer loads `DOOR_CYCLES-1`, the arrival bit is cleared, and `arrive` pulses.
  - On the `en` cycle with timer==0, the decision function is applied. It cannot re-select DOOR at the same floor, because that call is blocked while in DOOR.
- Boundaries:
  - The car never moves above `NUM_FLOORS-1` or below 0; the decision function guarantees this.
  - `dir` flips only on a reversal.
  - A request made at the arrival floor on the arrival edge is absorbed by that stop.

## Timing
- All outputs are registered. No combinational path runs from inputs to outputs.
- Idle to first floor step: 1 + `TRAVEL_CYCLES` enabled cycles. Each further floor costs `TRAVEL_CYCLES`.
- A call at the current floor while IDLE: the bit is latched on edge N, and DOOR is entered on the next `en` edge.
- DOOR lasts exactly `DOOR_CYCLES` enabled cycles unless the timer is reloaded.
- `en`=0: timer, state and `cur_floor` hold. Request latching continues.
- Asserting `rst` mid-move or mid-door returns every output to its reset value immediately; no partial state survives.

## Configuration
- `ELEVATOR_ESTOP_EN` defined:
  - Adds the `estop` input. While `estop`=1, state, timer, `cur_floor` and `dir` freeze, and `arrive` is forced to 0.
  - Requests still latch.
  - Operation resumes from the frozen point on the first cycle with `estop`=0.
- Not defined: no `estop` port; behaviour is identical to `estop` tied to 0.

## Structure
- `elevator_pkg` holds:
  - the `car_state_t` enum with encodings equal to the `sim_state` values;
  - the `dir_t` type (UP/DOWN);
  - the `SIM_*` constants shared with `vgaController`.
- One sub-module, `dwell_timer`: a loadable, enable-gated down-counter with a `zero` flag. It is instantiated once and shared between travel and door timing.

## Test plan
- Defaults with `TRAVEL_CYCLES`=4, `en`=1; pulse `call_req`=8'b0001_0000 from reset → at cycle 18: `cur_floor`=4, `sim_state`=11, `arrive`=1 for one cycle, `destination`=0.
- IDLE at floor 0; pulse `call_req`=8'h01 → DOOR two edges later; `door_open` stays high for 32 cycles, then IDLE.
- Car moving up through floor 2 with pending {0,5} → car stops at 5, then reverses and stops at 0. `sim_state` sequence: 01…11…10…11.
- `en` toggled 50% during MOVE → arrival time doubles; `call_req` pulses during `en`=0 still appear in `destination`.
- `rst` driven low mid-MOVE_DOWN at floor 3 → all outputs at reset values before the next edge; after release, `destination`=0.
- With `ELEVATOR_ESTOP_EN`, `estop` high for 10 cycles mid-travel → `cur_floor` and `sim_state` frozen, and arrival is delayed by exactly 10 cycles.
